pwm_duty_sequencer: RTL and testbench

Soft-start and slew controller that drives the signed 12-bit duty_ratio input of the motor PWM frequency-divider block. It accepts target duty commands through a valid/ready handshake and ramps toward each target by a programmable step once per PWM period. Direction reversals pass through zero with a dwell period. A fault input forces duty to 0 and latches the fault until it is cleared.

---
 rtl/pwm_seq_pkg.sv | 29 ++
 rtl/pwm_tick_gen.sv | 29 ++
 rtl/pwm_duty_sequencer.sv | 151 +++++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM duty sequencer.
// DUTY_CLAMP_EN (optional) enables command saturation to +/-MAX_DUTY.
package pwm_seq_pkg;

    localparam int DUTY_W       = 12;
    localparam int INT_W        = DUTY_W + 1;
    localparam int DEF_PERIOD   = 2000;
    localparam int DEF_MAX_DUTY = 670;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_HOLD  = 3'd2,
        S_DWELL = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    typedef logic signed [DUTY_W-1:0] duty_t;
    typedef logic signed [INT_W-1:0]  wide_t;

    function automatic duty_t sat_duty(input duty_t d, input int lim);
        duty_t r;
        r = d;
        if (int'(d) > lim) r = duty_t'(lim);
        else if (int'(d) < -lim) r = duty_t'(-lim);
        return r;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running period counter; tick pulses on the last count of each period.
module pwm_tick_gen
    import pwm_seq_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Soft-start / slew sequencer for the signed PWM duty ratio.
// Optional DUTY_CLAMP_EN saturates accepted commands to +/-MAX_DUTY.
module pwm_duty_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int PERIOD      = DEF_PERIOD,
    parameter int STEP_W      = 8,
    parameter int DWELL_TICKS = 4
`ifdef DUTY_CLAMP_EN
    ,
    parameter int MAX_DUTY    = DEF_MAX_DUTY
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     cmd_valid,
    input  logic signed [DUTY_W-1:0] cmd_duty,
    output logic                     cmd_ready,
    input  logic [STEP_W-1:0]        step_size,
    input  logic                     fault,
    input  logic                     fault_clr,
    output logic signed [DUTY_W-1:0] duty_ratio,
    output logic                     tick,
    output logic                     busy,
    output logic                     fault_latched,
    output logic [2:0]               state_o
);

    localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [DW-1:0] DW_LAST = DW'(DWELL_TICKS - 1);

    state_e        state_q, state_d;
    duty_t         duty_q, duty_d;
    duty_t         target_q, target_d;
    logic          fault_q, fault_d;
    logic [DW-1:0] dwell_q, dwell_d;

    duty_t cmd_val, eff, goal, stepv;
    wide_t diff, mag;
    logic  accept, rev;

    pwm_tick_gen #(.PERIOD(PERIOD)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

`ifdef DUTY_CLAMP_EN
    assign cmd_val = sat_duty(cmd_duty, MAX_DUTY);
`else
    assign cmd_val = cmd_duty;
`endif

    assign cmd_ready = rst_n && (state_q != S_FAULT);
    assign accept    = cmd_valid && cmd_ready;
    assign eff       = enable ? target_q : '0;
    assign stepv     = (step_size == '0) ? duty_t'(1)
                                         : duty_t'({1'b0, step_size});

    // A sign reversal first ramps to zero so the motor passes through a dwell
    assign rev  = (duty_q != '0) && (eff != '0)
               && (duty_q[DUTY_W-1] != eff[DUTY_W-1]);
    assign goal = rev ? '0 : eff;
    assign diff = {goal[DUTY_W-1], goal} - {duty_q[DUTY_W-1], duty_q};
    assign mag  = diff[INT_W-1] ? -diff : diff;

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = accept ? cmd_val : target_q;
        fault_d  = fault_q;
        dwell_d  = dwell_q;
        if (fault) begin
            state_d  = S_FAULT;
            duty_d   = '0;
            target_d = '0;
            fault_d  = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    duty_d = '0;
                    if (enable && eff != '0) state_d = S_RAMP;
                end
                S_RAMP: begin
                    if (tick) begin
                        if (mag <= {stepv[DUTY_W-1], stepv}) begin
                            duty_d = goal;
                            if (rev) begin
                                state_d = S_DWELL;
                                dwell_d = '0;
                            end else if (eff != '0 || enable) begin
                                state_d = S_HOLD;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else if (diff[INT_W-1]) begin
                            duty_d = duty_q - stepv;
                        end else begin
                            duty_d = duty_q + stepv;
                        end
                    end
                end
                S_DWELL: begin
                    duty_d = '0;
                    if (tick) begin
                        if (dwell_q == DW_LAST) state_d = S_RAMP;
                        else dwell_d = dwell_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (eff != duty_q) state_d = S_RAMP;
                end
                S_FAULT: begin
                    duty_d   = '0;
                    target_d = '0;
                    if (fault_clr) begin
                        state_d = S_IDLE;
                        fault_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    duty_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            duty_q   <= '0;
            target_q <= '0;
            fault_q  <= 1'b0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            fault_q  <= fault_d;
            dwell_q  <= dwell_d;
        end
    end

    assign duty_ratio    = duty_q;
    assign busy          = (state_q == S_RAMP) || (state_q == S_DWELL);
    assign fault_latched = fault_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed vector bench for pwm_duty_sequencer (short PERIOD for run time).
// Build with DUTY_CLAMP_EN to check the saturated command path.
module tb_pwm_duty_sequencer;

    localparam int P  = 16;
    localparam int SI = 0;
    localparam int SR = 1;
    localparam int SH = 2;
    localparam int SD = 3;
    localparam int SF = 4;
`ifdef DUTY_CLAMP_EN
    localparam int F = 670;
`else
    localparam int F = 2000;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              cmd_valid;
    logic signed [11:0] cmd_duty;
    logic              cmd_ready;
    logic [7:0]        step_size;
    logic              fault;
    logic              fault_clr;
    logic signed [11:0] duty_ratio;
    logic              tick;
    logic              busy;
    logic              fault_latched;
    logic [2:0]        state_o;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit en;
        int step;
        bit snd;
        int cmd;
        int nt;
        int duty;
        int st;
    } vec_t;

    vec_t tbl[19];

    pwm_duty_sequencer #(.PERIOD(P)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cmd_valid    (cmd_valid),
        .cmd_duty     (cmd_duty),
        .cmd_ready    (cmd_ready),
        .step_size    (step_size),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .duty_ratio   (duty_ratio),
        .tick         (tick),
        .busy         (busy),
        .fault_latched(fault_latched),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            int c = 0;
            while (tick !== 1'b1 && c < 3 * P) begin
                @(negedge clk);
                c++;
            end
            if (c >= 3 * P) chk("tick_timeout", 0, 1);
            @(negedge clk);
        end
    endtask

    task automatic send(input int d);
        cmd_valid = 1'b1;
        cmd_duty  = 12'(d);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic chk_sd(input string nm, input int d, input int s);
        int b;
        b = (s == SR || s == SD) ? 1 : 0;
        chk({nm, "_duty"}, int'(duty_ratio), d);
        chk({nm, "_state"}, int'(state_o), s);
        chk({nm, "_busy"}, int'(busy), b);
    endtask

    initial begin
        int first;
        int b;
        tbl[0]  = '{1'b1, 16, 1'b1, 100, 1, 16, SR};
        tbl[1]  = '{1'b1, 16, 1'b0, 0, 1, 32, SR};
        tbl[2]  = '{1'b1, 16, 1'b0, 0, 1, 48, SR};
        tbl[3]  = '{1'b1, 16, 1'b0, 0, 1, 64, SR};
        tbl[4]  = '{1'b1, 16, 1'b0, 0, 1, 80, SR};
        tbl[5]  = '{1'b1, 16, 1'b0, 0, 1, 96, SR};
        tbl[6]  = '{1'b1, 16, 1'b0, 0, 1, 100, SH};
        tbl[7]  = '{1'b1, 50, 1'b1, -50, 1, 50, SR};
        tbl[8]  = '{1'b1, 50, 1'b0, 0, 1, 0, SD};
        tbl[9]  = '{1'b1, 50, 1'b0, 0, 3, 0, SD};
        tbl[10] = '{1'b1, 50, 1'b0, 0, 1, 0, SR};
        tbl[11] = '{1'b1, 50, 1'b0, 0, 1, -50, SH};
        tbl[12] = '{1'b0, 100, 1'b0, 0, 1, 0, SI};
        tbl[13] = '{1'b1, 100, 1'b1, 300, 1, 100, SR};
        tbl[14] = '{1'b1, 100, 1'b0, 0, 1, 200, SR};
        tbl[15] = '{1'b1, 100, 1'b0, 0, 1, 300, SH};
        tbl[16] = '{1'b0, 100, 1'b0, 0, 1, 200, SR};
        tbl[17] = '{1'b0, 100, 1'b0, 0, 1, 100, SR};
        tbl[18] = '{1'b0, 100, 1'b0, 0, 1, 0, SI};

        rst_n = 1'b0;
        enable = 1'b1;
        cmd_valid = 1'b0;
        cmd_duty = '0;
        step_size = 8'd16;
        fault = 1'b0;
        fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_sd("reset", 0, SI);
        chk("reset_tick", int'(tick), 0);
        chk("reset_flt", int'(fault_latched), 0);
        chk("reset_rdy", int'(cmd_ready), 0);

        rst_n = 1'b1;
        first = -1;
        for (int i = 1; i <= P; i++) begin
            @(negedge clk);
            if (tick && first < 0) first = i;
        end
        chk("first_tick", first, P - 1);
        chk("post_reset_state", int'(state_o), SI);
        chk("post_reset_rdy", int'(cmd_ready), 1);

        for (int i = 0; i < 19; i++) begin
            enable = tbl[i].en;
            step_size = 8'(tbl[i].step);
            if (tbl[i].snd) send(tbl[i].cmd);
            wait_ticks(tbl[i].nt);
            chk_sd($sformatf("vec%0d", i), tbl[i].duty, tbl[i].st);
        end

        enable = 1'b1;
        step_size = 8'd16;
        send(100);
        wait_ticks(3);
        chk_sd("pre_fault", 48, SR);
        fault = 1'b1;
        cmd_valid = 1'b1;
        cmd_duty = 12'sd500;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk_sd("fault", 0, SF);
        chk("fault_rdy", int'(cmd_ready), 0);
        chk("fault_flt", int'(fault_latched), 1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("clr_ignored_state", int'(state_o), SF);
        chk("clr_ignored_flt", int'(fault_latched), 1);
        fault = 1'b0;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("clr_state", int'(state_o), SI);
        chk("clr_flt", int'(fault_latched), 0);
        chk("clr_rdy", int'(cmd_ready), 1);
        repeat (2 * P) @(negedge clk);
        chk_sd("target_cleared", 0, SI);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("clr_outside_fault", int'(state_o), SI);

        step_size = 8'd255;
        send(2000);
        wait_ticks(1);
        chk_sd("big_t1", 255, SR);
        wait_ticks(7);
        chk_sd("big_end", F, SH);

        step_size = 8'd0;
        send(F - 2);
        wait_ticks(1);
        chk_sd("step0_t1", F - 1, SR);
        wait_ticks(1);
        chk_sd("step0_t2", F - 2, SH);

        step_size = 8'd10;
        send(F - 102);
        wait_ticks(1);
        chk_sd("sim_t1", F - 12, SR);
        b = 0;
        while (tick !== 1'b1 && b < 3 * P) begin
            @(negedge clk);
            b++;
        end
        if (b >= 3 * P) chk("sim_align_timeout", 0, 1);
        send(F - 2);
        chk_sd("sim_old_target", F - 22, SR);
        wait_ticks(1);
        chk_sd("sim_new_target", F - 12, SR);
        wait_ticks(1);
        chk_sd("sim_done", F - 2, SH);

        fault = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_sd("rst_over_fault", 0, SI);
        chk("rst_over_fault_flt", int'(fault_latched), 0);
        chk("rst_over_fault_rdy", int'(cmd_ready), 0);
        fault = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
